// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input and flags a stuck level.
// Define PWM_CAPTURE_FILTER_EN to add a two-sample glitch filter after the synchroniser.
module pwm_capture #(
    parameter int TIMEOUT = 512
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwm_in,
    output logic [7:0] duty_out,
    output logic [9:0] period_out,
    output logic       valid,
    output logic       timeout
);
    typedef enum logic [1:0] {WAIT_FIRST, HIGH, LOW, STUCK} state_t;
    state_t     r_state, w_next;
    logic       r_s1, r_s2, r_s3;
    logic       w_level, w_rise, w_to;
    logic [9:0] r_period_cnt;
    logic [7:0] r_high_cnt;
    logic [7:0] r_duty;
    logic [9:0] r_period;
    logic       r_valid, r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= pwm_in;
            r_s2 <= r_s1;
            r_s3 <= w_level;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    // r_s1 holds the next s2 sample, so equality means two consecutive equal s2 samples
    logic r_filt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_filt <= 1'b0;
        else        r_filt <= (r_s1 == r_s2) ? r_s2 : r_filt;
    end
    assign w_level = r_filt;
`else
    assign w_level = r_s2;
`endif

    assign w_rise = w_level & ~r_s3;
    assign w_to   = (r_state != STUCK) && !w_rise && (r_period_cnt == 10'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        w_next = w_rise ? HIGH : w_to ? STUCK : (r_state == HIGH && !w_level) ? LOW : r_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= WAIT_FIRST;
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
            r_duty       <= '0;
            r_period     <= '0;
            r_valid      <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= 1'b0;
            if (w_rise) begin
                r_period_cnt <= 10'd1;
                r_high_cnt   <= 8'd1;
                r_timeout    <= 1'b0;
                // only a rise that closes a full HIGH/LOW cycle is a measurement
                if (r_state == LOW) begin
                    r_duty   <= r_high_cnt;
                    r_period <= r_period_cnt;
                    r_valid  <= 1'b1;
                end
            end else if (r_state != STUCK) begin
                r_period_cnt <= (r_period_cnt == 10'd1023) ? r_period_cnt : r_period_cnt + 10'd1;
                r_high_cnt   <= (w_level && r_high_cnt != 8'd255) ? r_high_cnt + 8'd1 : r_high_cnt;
                if (w_to) begin
                    r_duty    <= {8{w_level}};
                    r_period  <= '0;
                    r_valid   <= 1'b1;
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign duty_out   = r_duty;
    assign period_out = r_period;
    assign valid      = r_valid;
    assign timeout    = r_timeout;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: waveform-level scoreboard for pwm_capture; expected reports are queued as the input is driven.
module tb_pwm_capture;
    localparam int TO = 512;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int LAT  = 3;
    localparam bit FILT = 1'b1;
`else
    localparam int LAT  = 2;
    localparam bit FILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pwm_in = 1'b0;
    logic [7:0] duty_out;
    logic [9:0] period_out;
    logic       valid, timeout;

    pwm_capture #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
        .duty_out(duty_out), .period_out(period_out), .valid(valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int at;
        bit clr;
        int duty;
        int per;
        bit to;
    } exp_t;
    exp_t q[$];
    exp_t e;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(string tag, int got, int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_ev(int at, bit clr, int duty, int per, bit to);
        exp_t x;
        x.at = at; x.clr = clr; x.duty = duty; x.per = per; x.to = to;
        q.push_back(x);
    endtask

    // model state: 0 waiting for first rise, 1 measuring, 2 stuck
    bit m_prev;
    int m_state, m_rk, m_high;

    task automatic model(bit ml);
        int k = cyc + 1;
        if (ml && !m_prev) begin
            if (m_state == 1) push_ev(k + LAT, 1'b0, (m_high > 255) ? 255 : m_high, k - m_rk, 1'b0);
            else if (m_state == 2) push_ev(k + LAT, 1'b1, 0, 0, 1'b0);
            m_state = 1; m_rk = k; m_high = 1;
        end else if (m_state != 2) begin
            if (ml) m_high++;
            if (k - m_rk == TO - 1) begin
                push_ev(k + LAT, 1'b0, ml ? 255 : 0, 0, 1'b1);
                m_state = 2;
            end
        end
        m_prev = ml;
    endtask

    task automatic step(bit lvl, bit ml);
        @(negedge clk);
        pwm_in = lvl;
        model(ml);
    endtask

    task automatic hold(bit lvl, int n);
        repeat (n) step(lvl, lvl);
    endtask

    task automatic pwm(int h, int p, int n, int g);
        for (int j = 0; j < n; j++)
            for (int i = 0; i < p; i++)
                if (i == g) step(1'b1, !FILT);
                else step(i < h, i < h);
    endtask

    task automatic do_reset(int n, bit rel_lvl);
        @(negedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        check("rst_duty", duty_out, 0);
        check("rst_period", period_out, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        repeat (n) @(negedge clk);
        pwm_in = rel_lvl;
        rst_n = 1'b1;
        m_state = 0; m_prev = 1'b0; m_rk = cyc + 1 - LAT;
        model(rel_lvl);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0 && q[0].at < cyc) begin
            check("event_late", cyc, q[0].at);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].at == cyc) begin
            e = q.pop_front();
            if (e.clr) begin
                check("clr_valid", valid, 0);
                check("clr_timeout", timeout, 0);
            end else begin
                check("valid", valid, 1);
                check("duty", duty_out, e.duty);
                check("period", period_out, e.per);
                check("timeout", timeout, e.to);
            end
        end else begin
            check("idle_valid", valid, 0);
        end
    end

    initial begin
        do_reset(3, 1'b0);
        pwm(128, 256, 4, -1);
        pwm(1, 256, 2, -1);
        pwm(255, 256, 3, -1);
        hold(1'b0, 600);
        check("stuck_timeout", timeout, 1);
        check("stuck_duty", duty_out, 0);
        check("stuck_period", period_out, 0);
        pwm(64, 256, 3, -1);
        pwm(64, 256, 2, 150);
        pwm(300, 400, 3, -1);
        hold(1'b1, 100);
        do_reset(3, 1'b1);
        hold(1'b1, 600);
        check("stuck_hi_duty", duty_out, 255);
        hold(1'b0, 10);
        pwm(100, 256, 3, -1);
        hold(1'b1, 50);
        do_reset(2, 1'b0);
        pwm(100, 256, 3, -1);
        hold(1'b0, 10);
        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
